asym_fifo_n2w: RTL and testbench
================================

// Module: asym_fifo_n2w
// PURPOSE
// - Narrow-to-wide asymmetric FIFO: accepts 8-bit bytes, delivers 16-bit words.
// - Return path of the wide-write/narrow-read FIFO.
// - Sits between a byte-serial producer (e.g. UART RX) and a 16-bit consumer.
// - Includes byte storage, pointer/count control, full/empty status.
// - First byte written becomes the high byte of the word read.
// PARAMETERS
// - ADDR_WIDTH  3  byte-slot address width; depth = 2**ADDR_WIDTH bytes (>=2)
// - DATA_WIDTH  8  narrow (write) width; read width is 2*DATA_WIDTH
// PORTS
// - clk         in   1           single clock, all state on posedge
// - rst_n       in   1           asynchronous, active-low reset
// - wr          in   1           push request for w_data
// - w_data      in   DATA_WIDTH  byte to push
// - rd          in   1           pop request for one 16-bit word
// - r_data      out  2*DATA_WIDTH {older byte, newer byte} at read pointer
// - full        out  1           no free byte slot
// - empty       out  1           fewer than 2 bytes stored (no word ready)
// - byte_cnt    out  ADDR_WIDTH+1  bytes currently stored, 0..2**ADDR_WIDTH
// - err         out  1           sticky misuse flag (see CONFIGURATION)
// BEHAVIOUR
// - One clock clk; rst_n asynchronous active-low. Reset is asynchronous to clk.
// - Reset values:
//   - w_ptr=0, r_ptr=0, byte_cnt=0, full=0, empty=1, err=0.
//   - Storage is not cleared; r_data is don't-care while empty=1.
// - Storage: byte array mem[0:2**ADDR_WIDTH-1], written on posedge clk.
// - Push: wr=1 & full=0 -> mem[w_ptr]<=w_data, w_ptr+=1 (mod depth).
// - Pop: rd=1 & empty=0 -> r_ptr+=2 (mod depth).
// - Read port is fall-through (combinational):
//   - r_data = {mem[r_ptr], mem[r_ptr+1]}; valid same cycle empty=0.
//   - Consumer samples r_data in the cycle it asserts rd.
// - Wrap-around: pointer arithmetic is mod 2**ADDR_WIDTH; r_ptr stays even.
//   - r_ptr+1 never wraps mid-word.
// - byte_cnt: +1 on accepted push, -2 on accepted pop, -1 on both.
//   - full  = (byte_cnt == 2**ADDR_WIDTH), registered alongside byte_cnt.
//   - empty = (byte_cnt < 2); a single odd byte keeps empty=1.
// - Simultaneous wr & rd:
//   - Each is qualified only by the flags at that edge.
//   - A push while full is dropped even if a pop occurs that cycle.
//   - A pop while empty is ignored even if a push occurs that cycle.
// - Ignored requests leave pointers, byte_cnt and mem unchanged.
// - Reset mid-operation: all pointers/count clear immediately.
//   - Buffered bytes are discarded; the first post-reset push lands at slot 0.
// CONFIGURATION
// - Macro ASYM_FIFO_ERR_EN:
//   - Defined: err is a sticky register. It sets on posedge clk when
//     (wr & full) | (rd & empty), and clears only on rst_n=0.
//   - Undefined: err is tied to 0. Port list is unchanged.
// TESTING (defaults: depth 8)
// - Reset: rst_n=0 mid-stream -> empty=1, full=0, byte_cnt=0, err=0 asynchronously.
// - Ordering: push 8'hA1, 8'hB2 -> empty=0, r_data=16'hA1B2.
//   - Then rd -> empty=1, byte_cnt=0.
// - Odd byte: push 8'h11, 8'h22, 8'h33; pop once (r_data=16'h1122).
//   - Then byte_cnt=1, empty=1; push 8'h44 -> r_data=16'h3344.
// - Full/overflow:
//   - Push 8 bytes 8'h00..8'h07 -> full=1.
//   - 9th push 8'hFF is dropped; pops give 16'h0001, 16'h0203, 16'h0405, 16'h0607.
//   - err=1 only with ASYM_FIFO_ERR_EN defined.
// - Wrap + simultaneous: cycle through depth 3 times, with wr & rd in the same
//   cycles at byte_cnt=2..6.
//   - byte_cnt follows +1/-2/-1 rule; data order matches a scoreboard model.
// - Underflow: rd while empty -> no pointer change, byte_cnt=0.
//   - err=1 if ASYM_FIFO_ERR_EN, else 0.

Source files
------------

// File: rtl/asym_fifo_n2w.sv
// Narrow-to-wide asymmetric FIFO: byte writes, 16-bit fall-through word reads.
// Optional sticky misuse flag enabled by defining ASYM_FIFO_ERR_EN.
module asym_fifo_n2w #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    rd,
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    full,
    output logic                    empty,
    output logic [ADDR_WIDTH:0]     byte_cnt,
    output logic                    err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_odd;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  push, pop;

    // Fewer than two bytes stored means no complete word is available.
    assign empty = ~|cnt_q[ADDR_WIDTH:1];
    assign full  = full_q;
    assign byte_cnt = cnt_q;

    assign push = wr & ~full_q;
    assign pop  = rd & ~empty;

    // r_ptr is always even, so the second byte of a word never wraps.
    assign r_ptr_odd = r_ptr_q + ADDR_WIDTH'(1);
    assign r_data    = {mem[r_ptr_q], mem[r_ptr_odd]};

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        cnt_d   = cnt_q;
        if (push) begin
            w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop) begin
            r_ptr_d = r_ptr_q + ADDR_WIDTH'(2);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   cnt_d = cnt_q - (ADDR_WIDTH + 1)'(2);
            2'b11:   cnt_d = cnt_q - (ADDR_WIDTH + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d = (cnt_d == FULL_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[w_ptr_q] <= w_data;
        end
    end

`ifdef ASYM_FIFO_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((wr & full_q) | (rd & empty)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_asym_fifo_n2w.sv
// Self-checking bench for asym_fifo_n2w at default depth 8: vector table plus
// hand-written overflow, underflow, reset and wrap/simultaneous sequences.
module tb_asym_fifo_n2w;

`ifdef ASYM_FIFO_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic [7:0]  w_data;
    logic        rd;
    logic [15:0] r_data;
    logic        full;
    logic        empty;
    logic [3:0]  byte_cnt;
    logic        err;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  wd;
        logic        chk_data;
        logic [15:0] exp_data;
        logic        exp_empty;
        logic        exp_full;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs [9];
    logic [7:0] sb [$];
    logic [15:0] exp_word;
    logic [7:0]  wbyte;
    logic        r_req;
    logic        push_ok;
    logic        pop_ok;
    int          thr;

    asym_fifo_n2w #(
        .ADDR_WIDTH(3),
        .DATA_WIDTH(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (wr),
        .w_data  (w_data),
        .rd      (rd),
        .r_data  (r_data),
        .full    (full),
        .empty   (empty),
        .byte_cnt(byte_cnt),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of requests, return 1 time unit after the active edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        wr = w;
        rd = r;
        w_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_cnt", 32'(byte_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        wr = 1'b0;
        rd = 1'b0;
        w_data = 8'h00;
        rst_n = 1'b0;

        //           wr    rd    wd     chk   data      empty full  cnt
        vecs[0] = '{1'b1, 1'b0, 8'hA1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd1};
        vecs[1] = '{1'b1, 1'b0, 8'hB2, 1'b1, 16'hA1B2, 1'b0, 1'b0, 4'd2};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0};
        vecs[3] = '{1'b1, 1'b0, 8'h11, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd1};
        vecs[4] = '{1'b1, 1'b0, 8'h22, 1'b1, 16'h1122, 1'b0, 1'b0, 4'd2};
        vecs[5] = '{1'b1, 1'b0, 8'h33, 1'b1, 16'h1122, 1'b0, 1'b0, 4'd3};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd1};
        vecs[7] = '{1'b1, 1'b0, 8'h44, 1'b1, 16'h3344, 1'b0, 1'b0, 4'd2};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0};

        #12;
        chk("init_empty", 32'(empty), 32'd1);
        chk("init_full", 32'(full), 32'd0);
        chk("init_cnt", 32'(byte_cnt), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ordering and odd-byte handling.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].wd);
            chk($sformatf("vec%0d_cnt", i), 32'(byte_cnt), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'd0);
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d_data", i), 32'(r_data), 32'(vecs[i].exp_data));
            end
        end

        // Underflow: pop on empty must not move r_ptr.
        step(1'b0, 1'b1, 8'h00);
        chk("uflow_cnt", 32'(byte_cnt), 32'd0);
        chk("uflow_empty", 32'(empty), 32'd1);
        chk("uflow_err", 32'(err), 32'(ERR_EN));
        step(1'b1, 1'b0, 8'hC3);
        step(1'b1, 1'b0, 8'hD4);
        chk("uflow_data", 32'(r_data), 32'h0000C3D4);

        // Asynchronous reset mid-stream, then first push lands at slot 0.
        step(1'b1, 1'b0, 8'hE5);
        do_reset();
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'h66);
        chk("postrst_data", 32'(r_data), 32'h00005566);
        chk("postrst_cnt", 32'(byte_cnt), 32'd2);
        do_reset();

        // Fill, overflow, drain.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk($sformatf("fill%0d_full", i), 32'(full), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("fill_cnt", 32'(byte_cnt), 32'd8);
        step(1'b1, 1'b0, 8'hFF);
        chk("oflow_cnt", 32'(byte_cnt), 32'd8);
        chk("oflow_full", 32'(full), 32'd1);
        chk("oflow_err", 32'(err), 32'(ERR_EN));
        for (int i = 0; i < 4; i++) begin
            exp_word = {8'(2 * i), 8'(2 * i + 1)};
            chk($sformatf("drain%0d_data", i), 32'(r_data), 32'(exp_word));
            step(1'b0, 1'b1, 8'h00);
            chk($sformatf("drain%0d_cnt", i), 32'(byte_cnt), 32'(6 - 2 * i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_full", 32'(full), 32'd0);
        do_reset();

        // Wrap-around with simultaneous push/pop against a scoreboard.
        sb.delete();
        for (int i = 0; i < 48; i++) begin
            thr = 2 + (i / 8) % 5;
            wbyte = 8'(i * 7 + 3);
            r_req = (sb.size() >= thr);
            push_ok = (sb.size() != 8);
            pop_ok = r_req && (sb.size() >= 2);
            if (pop_ok) begin
                exp_word = {sb[0], sb[1]};
                chk($sformatf("wrap%0d_data", i), 32'(r_data), 32'(exp_word));
            end
            step(1'b1, r_req, wbyte);
            if (pop_ok) begin
                void'(sb.pop_front());
                void'(sb.pop_front());
            end
            if (push_ok) begin
                sb.push_back(wbyte);
            end
            chk($sformatf("wrap%0d_cnt", i), 32'(byte_cnt), 32'(sb.size()));
            chk($sformatf("wrap%0d_empty", i), 32'(empty), (sb.size() < 2) ? 32'd1 : 32'd0);
        end
        while (sb.size() >= 2) begin
            exp_word = {sb[0], sb[1]};
            chk("wrapdrain_data", 32'(r_data), 32'(exp_word));
            step(1'b0, 1'b1, 8'h00);
            void'(sb.pop_front());
            void'(sb.pop_front());
            chk("wrapdrain_cnt", 32'(byte_cnt), 32'(sb.size()));
        end
        chk("final_err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
